updi_rx_sequencer: RTL and testbench
====================================

# updi_rx_sequencer

Transaction-level controller for the UART receiver on the single-wire UPDI link. Every byte the host drives onto the half-duplex line is echoed back into the receiver. For each command, this block discards the echo bytes, captures the requested number of target response bytes into a small FIFO, and presents them as a valid/ready byte stream. It enforces an inactivity timeout and reports completion status to the UPDI command engine that sits above it.

## Interface
Parameters:
- DATA_BITS, 8, width of received data words; must match the receiver.
- MAX_LEN, 16, maximum echo or response byte count per transaction.
- FIFO_DEPTH, 4, response buffer depth; power of two, at least 2.
- TIMEOUT_CYCLES, 65536, clk cycles of receive inactivity before a transaction fails.

Ports:
- clk  in  1  logic clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  begin transaction; sampled only while idle.
- abort  in  1  cancel transaction; no done pulse is issued.
- echo_len  in  $clog2(MAX_LEN+1)  echo bytes to discard; sampled with start.
- resp_len  in  $clog2(MAX_LEN+1)  response bytes to capture; sampled with start.
- rx_data  in  DATA_BITS  data word from the UART receiver.
- rx_data_valid  in  1  one-cycle pulse from the receiver.
- rx_error  in  1  one-cycle parity-error pulse from the receiver.
- out_data  out  DATA_BITS  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- status  out  2  0 OK, 1 PARITY_ERR, 2 TIMEOUT, 3 OVERFLOW.

## Operation
- States: IDLE, ECHO, RESP, DONE.
- IDLE:
  - Receiver pulses are ignored.
  - On start, latch echo_len and resp_len, clear the remaining counters, and clear the timeout counter.
  - Next state is ECHO if echo_len≠0, else RESP if resp_len≠0, else DONE.
- ECHO: each rx_data_valid decrements the echo count and the byte is dropped. When the last echo byte arrives, go to RESP, or to DONE if resp_len=0.
- RESP: each rx_data_valid pushes rx_data into the FIFO and decrements the response count. When the last byte arrives, go to DONE with status OK.
- rx_error in ECHO or RESP: status PARITY_ERR, go to DONE. A byte already in the FIFO stays there.
- rx_data_valid in RESP with the FIFO full (and no pop in the same cycle): byte dropped, status OVERFLOW, go to DONE.
- Simultaneous pop and push on a full FIFO is legal and is not an overflow.
- Timeout:
  - The counter increments every cycle in ECHO or RESP in which there is no rx pulse.
  - It clears on any rx_data_valid or rx_error, and on every state entry.
  - When the counter equals TIMEOUT_CYCLES-1 and no pulse is present: status TIMEOUT, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- status is written on the cycle DONE is entered and holds until the next accepted start. start clears status to OK.
- abort in ECHO, RESP or DONE: go to IDLE next cycle, flush the FIFO, clear busy, no done pulse, status unchanged.
- abort has priority over start and over rx events.
- start while busy is ignored. Lengths above MAX_LEN are saturated to MAX_LEN.

## Timing
- Reset values: out_data 0, out_valid 0, busy 0, done 0, status OK, FIFO empty, state IDLE.
- start at cycle T puts busy high from T+1 through the DONE cycle inclusive.
- When echo_len=resp_len=0, done is high at T+1.
- A response byte whose rx_data_valid pulse is at cycle C appears with out_valid at C+1 if the FIFO was empty (out_data = FIFO head).
- done is high at C+1 after the final byte's pulse, or after the error, overflow or timeout event. The FIFO may still hold unread bytes at that point.
- The pop happens on the clk edge where out_valid && out_ready. out_valid drops the next cycle if the FIFO becomes empty.
- FIFO pointers carry one extra wrap bit. Full and empty are derived from the pointers.
- FIFO contents survive into IDLE until they are read, flushed by abort, or cleared by reset. Each new start does not flush.

## Structure
- The shared package updi_pkg holds:
  - enum rx_seq_state_t: IDLE, ECHO, RESP, DONE.
  - enum rx_seq_status_t: OK, PARITY_ERR, TIMEOUT, OVERFLOW.
- One sub-module: sync_fifo.
  - Parameters WIDTH and DEPTH.
  - Ports: push, pop, flush, full, empty, and data in/out.
  - Same clk and rst_n as this block.
- The sequencer FSM, length counters and timeout counter live in updi_rx_sequencer.

## Test plan
- echo_len=2, resp_len=1, then pulses with rx_data 0x55, 0x80, 0xA5 and out_ready=1 -> out_data 0xA5 exactly once, done one cycle after the third pulse, status OK.
- echo_len=0, resp_len=0, start -> done at T+1, busy high for one cycle, FIFO still empty.
- resp_len=6, out_ready=0, six pulses 0x01..0x06 -> four bytes buffered, status OVERFLOW on the fifth pulse, done next cycle; draining yields 0x01..0x04.
- resp_len=2 with TIMEOUT_CYCLES=16, one pulse then silence -> done with status TIMEOUT 16 cycles after that pulse; the first byte is still readable.
- resp_len=3, rx_error on the second byte -> status PARITY_ERR, done next cycle; then abort mid-transaction on a retry -> busy low, no done pulse, out_valid=0.
- Assert rst_n low mid-RESP -> all outputs at reset values immediately, without waiting for a clk edge; after release, a start is accepted normally.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared types for the UPDI receive path: sequencer states and completion status codes.
package updi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ECHO,
    RESP,
    DONE
  } rx_seq_state_t;

  typedef enum logic [1:0] {
    OK,
    PARITY_ERR,
    TIMEOUT,
    OVERFLOW
  } rx_seq_status_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and empty come from the pointers alone.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push into a full FIFO is accepted then.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/updi_rx_sequencer.sv
// UPDI receive transaction controller: drops echo bytes, buffers response bytes,
// enforces an inactivity timeout and reports completion status.
module updi_rx_sequencer
  import updi_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [$clog2(MAX_LEN+1)-1:0] echo_len,
  input  logic [$clog2(MAX_LEN+1)-1:0] resp_len,
  input  logic [DATA_BITS-1:0]         rx_data,
  input  logic                         rx_data_valid,
  input  logic                         rx_error,
  output logic [DATA_BITS-1:0]         out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   status
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  rx_seq_state_t  state;
  rx_seq_status_t status_q;
  rx_seq_status_t fin_status;
  logic [LW-1:0]  echo_cnt;
  logic [LW-1:0]  resp_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           fin;
  logic           to_resp;
  logic           push;
  logic           pop;
  logic           flush;
  logic           fifo_full;
  logic           fifo_empty;
  logic           active;

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
    return (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  endfunction

  assign active    = (state == ECHO) || (state == RESP);
  assign pop       = out_ready && !fifo_empty;
  assign flush     = abort && (state != IDLE);
  assign out_valid = !fifo_empty;
  assign status    = status_q;

  // Per-cycle event decode for the receive states; abort is applied on top of this in the register block.
  always_comb begin
    fin        = 1'b0;
    fin_status = OK;
    to_resp    = 1'b0;
    push       = 1'b0;
    if (active) begin
      if (rx_error) begin
        fin        = 1'b1;
        fin_status = PARITY_ERR;
      end else if (rx_data_valid) begin
        if (state == ECHO) begin
          if (echo_cnt == LW'(1)) begin
            if (resp_cnt != '0) to_resp = 1'b1;
            else                fin     = 1'b1;
          end
        end else if (fifo_full && !pop) begin
          fin        = 1'b1;
          fin_status = OVERFLOW;
        end else begin
          push = 1'b1;
          if (resp_cnt == LW'(1)) fin = 1'b1;
        end
      end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        fin        = 1'b1;
        fin_status = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      status_q <= OK;
      echo_cnt <= '0;
      resp_cnt <= '0;
      tmo_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        if (start && !abort) begin
          echo_cnt <= sat_len(echo_len);
          resp_cnt <= sat_len(resp_len);
          tmo_cnt  <= '0;
          status_q <= OK;
          busy     <= 1'b1;
          if (echo_len != '0) begin
            state <= ECHO;
          end else if (resp_len != '0) begin
            state <= RESP;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end else if (state == DONE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        if (fin) begin
          state    <= DONE;
          done     <= 1'b1;
          status_q <= fin_status;
        end else if (to_resp) begin
          state <= RESP;
        end
        if (rx_error || rx_data_valid || fin || to_resp) tmo_cnt <= '0;
        else                                             tmo_cnt <= tmo_cnt + 1'b1;
        if (rx_data_valid && !rx_error) begin
          if (state == ECHO) echo_cnt <= echo_cnt - 1'b1;
          else               resp_cnt <= resp_cnt - 1'b1;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push && !abort),
    .pop    (pop),
    .flush  (flush),
    .wr_data(rx_data),
    .rd_data(out_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

endmodule

// File: tb/tb_updi_rx_sequencer.sv
// Bench for updi_rx_sequencer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level queue model.
module tb_updi_rx_sequencer;

  localparam int unsigned DW  = 8;
  localparam int unsigned ML  = 16;
  localparam int unsigned FD  = 4;
  localparam int unsigned TMO = 16;
  localparam int unsigned LW  = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] echo_len = '0;
  logic [LW-1:0] resp_len = '0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_data_valid = 1'b0;
  logic          rx_error = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [1:0]    status;

  int checks = 0;
  int failures = 0;

  // Model: a transaction is either in flight (m_active), in its completion cycle (m_done), or absent.
  logic [DW-1:0] mq[$];
  bit            m_active = 1'b0;
  bit            m_done = 1'b0;
  int            m_status = 0;
  int            echo_left = 0;
  int            resp_left = 0;
  int            silent = 0;

  updi_rx_sequencer #(
    .DATA_BITS     (DW),
    .MAX_LEN       (ML),
    .FIFO_DEPTH    (FD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .echo_len     (echo_len),
    .resp_len     (resp_len),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .rx_error     (rx_error),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .status       (status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_status = 0;
    silent   = 0;
  endtask

  task automatic finish_txn(input int st);
    m_active = 1'b0;
    m_done   = 1'b1;
    m_status = st;
  endtask

  task automatic model_step();
    int  pre_size;
    bit  do_pop;
    pre_size = mq.size();
    do_pop   = (pre_size != 0) && out_ready;
    if (abort && (m_active || m_done)) begin
      mq.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      return;
    end
    if (do_pop) void'(mq.pop_front());
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start && !abort) begin
        echo_left = (int'(echo_len) > ML) ? ML : int'(echo_len);
        resp_left = (int'(resp_len) > ML) ? ML : int'(resp_len);
        m_status  = 0;
        silent    = 0;
        if (echo_left == 0 && resp_left == 0) m_done = 1'b1;
        else                                  m_active = 1'b1;
      end
    end else if (rx_error) begin
      finish_txn(1);
    end else if (rx_data_valid) begin
      silent = 0;
      if (echo_left > 0) begin
        echo_left--;
        if (echo_left == 0 && resp_left == 0) finish_txn(0);
      end else if (pre_size == FD && !do_pop) begin
        finish_txn(3);
      end else begin
        mq.push_back(rx_data);
        resp_left--;
        if (resp_left == 0) finish_txn(0);
      end
    end else begin
      silent++;
      if (silent == TMO) finish_txn(2);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic rx(input logic [DW-1:0] d, input bit err);
    rx_data       = d;
    rx_data_valid = !err;
    rx_error      = err;
    tick();
    rx_data_valid = 1'b0;
    rx_error      = 1'b0;
  endtask

  task automatic go(input int e, input int r);
    echo_len = LW'(e);
    resp_len = LW'(r);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_active || m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("status", 32'(status), 32'(m_status));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  initial begin
    int n;
    int quiet;
    bit last_pulse;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_out_data", 32'(out_data), 0);
    rst_n = 1'b1;
    tick();

    // Echo 2, response 1.
    out_ready = 1'b1;
    go(2, 1);
    rx(8'h55, 1'b0);
    rx(8'h80, 1'b0);
    chk("s1_no_early_done", 32'(done), 0);
    rx(8'hA5, 1'b0);
    chk("s1_done", 32'(done), 1);
    chk("s1_status", 32'(status), 0);
    chk("s1_valid", 32'(out_valid), 1);
    chk("s1_data", 32'(out_data), 32'h A5);
    tick();
    chk("s1_popped", 32'(out_valid), 0);
    chk("s1_idle", 32'(busy), 0);

    // Zero-length transaction.
    go(0, 0);
    chk("s2_done", 32'(done), 1);
    chk("s2_busy", 32'(busy), 1);
    chk("s2_empty", 32'(out_valid), 0);
    tick();
    chk("s2_done_low", 32'(done), 0);
    chk("s2_busy_low", 32'(busy), 0);

    // Overflow with a stalled consumer.
    out_ready = 1'b0;
    go(0, 6);
    for (int i = 1; i <= 4; i++) rx(DW'(i), 1'b0);
    chk("s3_not_done", 32'(done), 0);
    rx(8'h05, 1'b0);
    chk("s3_done", 32'(done), 1);
    chk("s3_overflow", 32'(status), 3);
    rx(8'h06, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("s3_drain_valid", 32'(out_valid), 1);
      chk("s3_drain_data", 32'(out_data), i);
      tick();
    end
    chk("s3_drained", 32'(out_valid), 0);
    chk("s3_status_hold", 32'(status), 3);

    // Timeout after one response byte.
    out_ready = 1'b0;
    go(0, 2);
    rx(8'h3C, 1'b0);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("s4_latency", n, 16);
    chk("s4_status", 32'(status), 2);
    chk("s4_byte_kept", 32'(out_data), 32'h3C);
    tick();

    // Parity error, then abort on retry.
    go(0, 3);
    rx(8'h11, 1'b0);
    rx(8'h00, 1'b1);
    chk("s5_done", 32'(done), 1);
    chk("s5_parity", 32'(status), 1);
    tick();
    go(0, 3);
    rx(8'h22, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_abort_busy", 32'(busy), 0);
    chk("s5_abort_done", 32'(done), 0);
    chk("s5_abort_flush", 32'(out_valid), 0);
    tick();
    chk("s5_no_late_done", 32'(done), 0);

    // Asynchronous reset in the middle of a response.
    go(0, 4);
    rx(8'h01, 1'b0);
    rx(8'h02, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_busy", 32'(busy), 0);
    chk("s6_valid", 32'(out_valid), 0);
    chk("s6_status", 32'(status), 0);
    chk("s6_data", 32'(out_data), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    go(1, 1);
    rx(8'h09, 1'b0);
    rx(8'h07, 1'b0);
    chk("s6_restart_done", 32'(done), 1);
    chk("s6_restart_data", 32'(out_data), 32'h07);
    out_ready = 1'b1;
    tick();
    tick();

    // Randomized traffic against the model.
    quiet = 0;
    last_pulse = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 79) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) begin
        echo_len = LW'($urandom_range(0, 20));
        resp_len = LW'($urandom_range(0, 20));
      end else begin
        echo_len = LW'($urandom_range(0, 3));
        resp_len = LW'($urandom_range(0, 6));
      end
      if (quiet == 0 && $urandom_range(0, 99) == 0) quiet = $urandom_range(10, 25);
      rx_data       = DW'($urandom);
      rx_data_valid = 1'b0;
      rx_error      = 1'b0;
      if (quiet > 0) begin
        quiet--;
      end else if (!last_pulse) begin
        if ($urandom_range(0, 99) == 0)      rx_error      = 1'b1;
        else if ($urandom_range(0, 1) == 1)  rx_data_valid = 1'b1;
      end
      last_pulse = rx_data_valid || rx_error;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rx_data_valid = 1'b0;
    rx_error = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
